// File: rtl/key_load_controller_pkg.sv
// Shared definitions for the logic-locking key loader: state encoding,
// default key geometry and the bit offsets of each lock module's key slice.
package key_load_controller_pkg;

   localparam int KEY_BYTES_DEF = 8;
   localparam int MAX_FAILS_DEF = 3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_CHECK   = 3'd2,
      ST_ARMED   = 3'd3,
      ST_ERROR   = 3'd4,
      ST_LOCKOUT = 3'd5
   } kl_state_e;

   // LSB of each lock module's 8-bit slice inside key_out
   localparam int KEY_OFS_MAIN_DEC = 0;
   localparam int KEY_OFS_ALU_DEC  = 8;
   localparam int KEY_OFS_IMM_GEN  = 16;
   localparam int KEY_OFS_BRANCH   = 24;
   localparam int KEY_OFS_LSU      = 32;
   localparam int KEY_OFS_CSR      = 40;
   localparam int KEY_OFS_REGFILE  = 48;
   localparam int KEY_OFS_FWD      = 56;

   // LSB of the slice belonging to lock module number lock_idx
   function automatic int key_slice_lsb(input int lock_idx);
      return 8 * lock_idx;
   endfunction

endpackage

// File: rtl/key_shadow_reg.sv
// Byte-addressed shadow register for the key being assembled, plus the
// published key register. The published copy is taken from the shadow's
// next value, so a byte written on the publishing edge is included.
module key_shadow_reg
   import key_load_controller_pkg::*;
#(
   parameter int KEY_BYTES = KEY_BYTES_DEF,
   parameter int IW        = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   wr_en,
   input  logic [IW-1:0]          wr_idx,
   input  logic [7:0]             wr_data,
   input  logic                   publish,
   output logic [8*KEY_BYTES-1:0] key_out
);

   logic [8*KEY_BYTES-1:0] shadow_r;
   logic [8*KEY_BYTES-1:0] shadow_next_s;
   logic [8*KEY_BYTES-1:0] key_r;

   // Next shadow contents: clear wins over a byte write
   always_comb begin
      shadow_next_s = shadow_r;
      if (clr) begin
         shadow_next_s = '0;
      end else if (wr_en) begin
         for (int i = 0; i < KEY_BYTES; i++) begin
            if (wr_idx == IW'(i)) begin
               shadow_next_s[8*i +: 8] = wr_data;
            end else begin
               shadow_next_s[8*i +: 8] = shadow_r[8*i +: 8];
            end
         end
      end else begin
         shadow_next_s = shadow_r;
      end
   end

   // Shadow and published key registers; key only changes on publish
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_r <= '0;
         key_r    <= '0;
      end else begin
         shadow_r <= shadow_next_s;
         if (publish) begin
            key_r <= shadow_next_s;
         end else begin
            key_r <= key_r;
         end
      end
   end

   assign key_out = key_r;

endmodule

// File: rtl/key_load_controller.sv
// Post-reset key load sequencer for the logic-locked decode path.
// Optional checksum verification (CHECK/ERROR/LOCKOUT, fail counter) is
// built only when KEYLD_CHECKSUM_EN is defined; otherwise a load is exactly
// KEY_BYTES bytes followed directly by ARMED.
module key_load_controller
   import key_load_controller_pkg::*;
#(
   parameter int KEY_BYTES = KEY_BYTES_DEF,
   parameter int MAX_FAILS = MAX_FAILS_DEF
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [7:0]                     key_in,
   input  logic                           key_valid,
   output logic                           key_ready,
   output logic [8*KEY_BYTES-1:0]         key_out,
   output logic                           armed,
   output logic                           busy,
   output logic                           error,
   output logic                           lockout,
   output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);

   localparam int IW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
   localparam int FW = $clog2(MAX_FAILS + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(KEY_BYTES - 1);

   kl_state_e     state_r;
   logic [IW-1:0] idx_r;
   logic          key_ready_r;
   logic          busy_r;
   logic          armed_r;
   logic          accept_s;
   logic          sh_clr_s;
   logic          sh_wr_s;
   logic          sh_pub_s;
`ifdef KEYLD_CHECKSUM_EN
   logic [7:0]    sum_r;
   logic          error_r;
   logic          lockout_r;
   logic [FW-1:0] fail_cnt_r;
   logic          sum_match_s;

   assign sum_match_s = (key_in == sum_r);
`endif

   // key_ready is a registered state decode, so acceptance is a plain AND
   assign accept_s = key_valid && key_ready_r;

   // Shadow register control derived from state and the accepted byte
   always_comb begin
      sh_clr_s = 1'b0;
      sh_wr_s  = 1'b0;
      sh_pub_s = 1'b0;
      case (state_r)
         ST_IDLE, ST_ERROR: begin
            if (start) begin
               sh_clr_s = 1'b1;
            end else begin
               sh_clr_s = 1'b0;
            end
         end
         ST_LOAD: begin
            if (accept_s) begin
               sh_wr_s = 1'b1;
`ifndef KEYLD_CHECKSUM_EN
               if (idx_r == LAST_IDX) begin
                  sh_pub_s = 1'b1;
               end else begin
                  sh_pub_s = 1'b0;
               end
`endif
            end else begin
               sh_wr_s = 1'b0;
            end
         end
`ifdef KEYLD_CHECKSUM_EN
         ST_CHECK: begin
            if (accept_s && sum_match_s) begin
               sh_pub_s = 1'b1;
            end else if (accept_s) begin
               sh_clr_s = 1'b1;
            end else begin
               sh_pub_s = 1'b0;
               sh_clr_s = 1'b0;
            end
         end
`endif
         default: begin
            sh_clr_s = 1'b0;
            sh_wr_s  = 1'b0;
            sh_pub_s = 1'b0;
         end
      endcase
   end

   // Load sequencer with registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         idx_r       <= '0;
         key_ready_r <= 1'b0;
         busy_r      <= 1'b0;
         armed_r     <= 1'b0;
`ifdef KEYLD_CHECKSUM_EN
         sum_r       <= 8'h00;
         error_r     <= 1'b0;
         lockout_r   <= 1'b0;
         fail_cnt_r  <= '0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_r     <= ST_LOAD;
                  idx_r       <= '0;
                  key_ready_r <= 1'b1;
                  busy_r      <= 1'b1;
`ifdef KEYLD_CHECKSUM_EN
                  sum_r       <= 8'h00;
`endif
               end
            end
            ST_LOAD: begin
               if (accept_s) begin
`ifdef KEYLD_CHECKSUM_EN
                  sum_r <= sum_r ^ key_in;
`endif
                  if (idx_r == LAST_IDX) begin
                     idx_r <= '0;
`ifdef KEYLD_CHECKSUM_EN
                     state_r <= ST_CHECK;
`else
                     state_r     <= ST_ARMED;
                     key_ready_r <= 1'b0;
                     busy_r      <= 1'b0;
                     armed_r     <= 1'b1;
`endif
                  end else begin
                     idx_r <= idx_r + IW'(1);
                  end
               end
            end
`ifdef KEYLD_CHECKSUM_EN
            ST_CHECK: begin
               if (accept_s) begin
                  key_ready_r <= 1'b0;
                  busy_r      <= 1'b0;
                  if (sum_match_s) begin
                     state_r <= ST_ARMED;
                     armed_r <= 1'b1;
                  end else begin
                     if (fail_cnt_r != FW'(MAX_FAILS)) begin
                        fail_cnt_r <= fail_cnt_r + FW'(1);
                     end
                     if (fail_cnt_r + FW'(1) >= FW'(MAX_FAILS)) begin
                        state_r   <= ST_LOCKOUT;
                        lockout_r <= 1'b1;
                        error_r   <= 1'b0;
                     end else begin
                        state_r <= ST_ERROR;
                        error_r <= 1'b1;
                     end
                  end
               end
            end
            ST_ERROR: begin
               if (start) begin
                  state_r     <= ST_LOAD;
                  idx_r       <= '0;
                  sum_r       <= 8'h00;
                  key_ready_r <= 1'b1;
                  busy_r      <= 1'b1;
                  error_r     <= 1'b0;
               end
            end
            ST_LOCKOUT: begin
               state_r <= ST_LOCKOUT;
            end
`endif
            ST_ARMED: begin
               state_r <= ST_ARMED;
            end
            default: begin
               state_r     <= ST_IDLE;
               idx_r       <= '0;
               key_ready_r <= 1'b0;
               busy_r      <= 1'b0;
               armed_r     <= 1'b0;
            end
         endcase
      end
   end

   key_shadow_reg #(
      .KEY_BYTES (KEY_BYTES),
      .IW        (IW)
   ) u_shadow (
      .clk     (clk),
      .rst     (rst),
      .clr     (sh_clr_s),
      .wr_en   (sh_wr_s),
      .wr_idx  (idx_r),
      .wr_data (key_in),
      .publish (sh_pub_s),
      .key_out (key_out)
   );

   assign key_ready = key_ready_r;
   assign busy      = busy_r;
   assign armed     = armed_r;
`ifdef KEYLD_CHECKSUM_EN
   assign error     = error_r;
   assign lockout   = lockout_r;
   assign fail_cnt  = fail_cnt_r;
`else
   assign error     = 1'b0;
   assign lockout   = 1'b0;
   assign fail_cnt  = '0;
`endif

endmodule

// File: tb/tb_key_load_controller.sv
// Directed bench for key_load_controller. Checksum scenarios are exercised
// when KEYLD_CHECKSUM_EN is defined; otherwise the direct-arm path is checked.
module tb_key_load_controller;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  key_in;
   logic        key_valid;
   logic        key_ready;
   logic [63:0] key_out;
   logic        armed;
   logic        busy;
   logic        error;
   logic        lockout;
   logic [1:0]  fail_cnt;

   int n_checks = 0;
   int n_fails  = 0;

   localparam logic [63:0] KEY_A = 64'h7766554433221157;
   localparam logic [7:0]  CS_A  = 8'h57;
   localparam logic [63:0] KEY_B = 64'h0807060504030201;
   localparam logic [7:0]  CS_B  = 8'h08;

   key_load_controller dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .key_in    (key_in),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_out   (key_out),
      .armed     (armed),
      .busy      (busy),
      .error     (error),
      .lockout   (lockout),
      .fail_cnt  (fail_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; key_valid = 1'b0; key_in = 8'h00;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      key_in = b; key_valid = 1'b1;
      tick();
      key_valid = 1'b0; key_in = 8'h00;
   endtask

   // start, all key bytes back to back, then the checksum byte if built in
   task automatic load_key(input logic [63:0] k, input logic [7:0] cs);
      pulse_start();
      for (int i = 0; i < 8; i++) send_byte(k[8*i +: 8]);
`ifdef KEYLD_CHECKSUM_EN
      send_byte(cs);
`endif
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (key_out !== 64'h0) begin n_fails++; $display("FAIL reset_key_out got %h want 0", key_out); end
      n_checks++; if (armed !== 1'b0) begin n_fails++; $display("FAIL reset_armed got %b want 0", armed); end
      n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (error !== 1'b0 || lockout !== 1'b0) begin n_fails++; $display("FAIL reset_err_lock got %b%b want 00", error, lockout); end
      n_checks++; if (fail_cnt !== 2'd0) begin n_fails++; $display("FAIL reset_fail_cnt got %0d want 0", fail_cnt); end
      for (int c = 0; c < 20; c++) begin
         tick();
         n_checks++;
         if (key_out !== 64'h0 || armed !== 1'b0 || key_ready !== 1'b0) begin
            n_fails++; $display("FAIL idle_cycle%0d got key_out=%h armed=%b ready=%b want 0/0/0", c, key_out, armed, key_ready);
         end
      end
   endtask

   task automatic test_good_load();
      do_reset();
      pulse_start();
      n_checks++; if (key_ready !== 1'b1 || busy !== 1'b1) begin n_fails++; $display("FAIL start_ready got ready=%b busy=%b want 1/1", key_ready, busy); end
      for (int i = 0; i < 8; i++) send_byte(KEY_A[8*i +: 8]);
`ifdef KEYLD_CHECKSUM_EN
      n_checks++; if (armed !== 1'b0 || key_out !== 64'h0) begin n_fails++; $display("FAIL check_no_partial got armed=%b key_out=%h want 0/0", armed, key_out); end
      n_checks++; if (key_ready !== 1'b1) begin n_fails++; $display("FAIL check_ready got %b want 1", key_ready); end
      send_byte(CS_A);
`endif
      n_checks++; if (armed !== 1'b1) begin n_fails++; $display("FAIL good_armed got %b want 1", armed); end
      n_checks++; if (key_out !== KEY_A) begin n_fails++; $display("FAIL good_key got %h want %h", key_out, KEY_A); end
      n_checks++; if (key_out[7:0] !== 8'h57) begin n_fails++; $display("FAIL good_slice0 got %h want 57", key_out[7:0]); end
      n_checks++; if (key_ready !== 1'b0 || busy !== 1'b0) begin n_fails++; $display("FAIL good_idle got ready=%b busy=%b want 0/0", key_ready, busy); end
      // ARMED ignores start and further bytes
      start = 1'b1; key_in = 8'hAA; key_valid = 1'b1;
      tick();
      start = 1'b0; key_valid = 1'b0;
      tick();
      n_checks++; if (key_out !== KEY_A || armed !== 1'b1 || key_ready !== 1'b0) begin n_fails++; $display("FAIL armed_hold got key=%h armed=%b ready=%b want %h/1/0", key_out, armed, key_ready, KEY_A); end
      n_checks++; if (error !== 1'b0 || fail_cnt !== 2'd0) begin n_fails++; $display("FAIL good_no_err got err=%b cnt=%0d want 0/0", error, fail_cnt); end
      // rst while ARMED returns outputs to reset values
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (key_out !== 64'h0 || armed !== 1'b0) begin n_fails++; $display("FAIL armed_rst got key=%h armed=%b want 0/0", key_out, armed); end
   endtask

`ifdef KEYLD_CHECKSUM_EN
   task automatic test_bad_checksum();
      do_reset();
      load_key(KEY_A, 8'h00);
      n_checks++; if (error !== 1'b1) begin n_fails++; $display("FAIL bad_error got %b want 1", error); end
      n_checks++; if (fail_cnt !== 2'd1) begin n_fails++; $display("FAIL bad_cnt got %0d want 1", fail_cnt); end
      n_checks++; if (key_out !== 64'h0 || armed !== 1'b0) begin n_fails++; $display("FAIL bad_key got key=%h armed=%b want 0/0", key_out, armed); end
      n_checks++; if (key_ready !== 1'b0 || busy !== 1'b0) begin n_fails++; $display("FAIL bad_idle got ready=%b busy=%b want 0/0", key_ready, busy); end
      pulse_start();
      n_checks++; if (error !== 1'b0 || key_ready !== 1'b1) begin n_fails++; $display("FAIL retry_start got err=%b ready=%b want 0/1", error, key_ready); end
      for (int i = 0; i < 8; i++) send_byte(KEY_A[8*i +: 8]);
      send_byte(CS_A);
      n_checks++; if (armed !== 1'b1 || error !== 1'b0 || key_out !== KEY_A) begin n_fails++; $display("FAIL retry_good got armed=%b err=%b key=%h want 1/0/%h", armed, error, key_out, KEY_A); end
      n_checks++; if (fail_cnt !== 2'd1) begin n_fails++; $display("FAIL retry_cnt got %0d want 1", fail_cnt); end
   endtask

   task automatic test_lockout();
      do_reset();
      load_key(KEY_A, 8'h01);
      load_key(KEY_A, 8'h02);
      n_checks++; if (error !== 1'b1 || fail_cnt !== 2'd2 || lockout !== 1'b0) begin n_fails++; $display("FAIL second_bad got err=%b cnt=%0d lock=%b want 1/2/0", error, fail_cnt, lockout); end
      load_key(KEY_A, 8'h03);
      n_checks++; if (lockout !== 1'b1 || fail_cnt !== 2'd3) begin n_fails++; $display("FAIL lockout got lock=%b cnt=%0d want 1/3", lockout, fail_cnt); end
      n_checks++; if (key_out !== 64'h0 || armed !== 1'b0) begin n_fails++; $display("FAIL lockout_key got key=%h armed=%b want 0/0", key_out, armed); end
      pulse_start();
      n_checks++; if (key_ready !== 1'b0 || busy !== 1'b0) begin n_fails++; $display("FAIL lockout_start got ready=%b busy=%b want 0/0", key_ready, busy); end
      send_byte(8'h57);
      n_checks++; if (lockout !== 1'b1 || fail_cnt !== 2'd3 || key_out !== 64'h0) begin n_fails++; $display("FAIL lockout_hold got lock=%b cnt=%0d key=%h want 1/3/0", lockout, fail_cnt, key_out); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (lockout !== 1'b0 || fail_cnt !== 2'd0 || error !== 1'b0 || key_ready !== 1'b0) begin n_fails++; $display("FAIL lockout_rst got lock=%b cnt=%0d err=%b ready=%b want 0/0/0/0", lockout, fail_cnt, error, key_ready); end
   endtask
`else
   task automatic test_no_checksum_flags();
      do_reset();
      load_key(KEY_B, CS_B);
      n_checks++; if (error !== 1'b0 || lockout !== 1'b0 || fail_cnt !== 2'd0) begin n_fails++; $display("FAIL nocs_flags got err=%b lock=%b cnt=%0d want 0/0/0", error, lockout, fail_cnt); end
      n_checks++; if (armed !== 1'b1 || key_out !== KEY_B) begin n_fails++; $display("FAIL nocs_key got armed=%b key=%h want 1/%h", armed, key_out, KEY_B); end
   endtask
`endif

   task automatic test_back_pressure();
      do_reset();
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         send_byte(KEY_B[8*i +: 8]);
         // idle gap with junk data; start mid-load must not restart the load
         key_in = 8'hFF; key_valid = 1'b0;
         if (i == 3) start = 1'b1; else start = 1'b0;
         tick();
         start = 1'b0;
         if (i == 3) begin
            n_checks++; if (key_ready !== 1'b1 || busy !== 1'b1 || armed !== 1'b0) begin n_fails++; $display("FAIL gap_mid got ready=%b busy=%b armed=%b want 1/1/0", key_ready, busy, armed); end
         end
      end
`ifdef KEYLD_CHECKSUM_EN
      n_checks++; if (busy !== 1'b1 || armed !== 1'b0) begin n_fails++; $display("FAIL gap_check got busy=%b armed=%b want 1/0", busy, armed); end
      send_byte(CS_B);
`endif
      n_checks++; if (armed !== 1'b1 || key_out !== KEY_B) begin n_fails++; $display("FAIL gap_key got armed=%b key=%h want 1/%h", armed, key_out, KEY_B); end
   endtask

   task automatic test_reset_mid_load();
      do_reset();
      pulse_start();
      for (int i = 0; i < 4; i++) send_byte(KEY_B[8*i +: 8]);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (key_ready !== 1'b0 || busy !== 1'b0 || key_out !== 64'h0 || armed !== 1'b0) begin n_fails++; $display("FAIL midrst got ready=%b busy=%b key=%h armed=%b want 0/0/0/0", key_ready, busy, key_out, armed); end
      load_key(KEY_A, CS_A);
      n_checks++; if (armed !== 1'b1 || key_out !== KEY_A) begin n_fails++; $display("FAIL midrst_reload got armed=%b key=%h want 1/%h", armed, key_out, KEY_A); end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; key_in = 8'h00; key_valid = 1'b0;
      test_reset();
      test_good_load();
`ifdef KEYLD_CHECKSUM_EN
      test_bad_checksum();
      test_lockout();
`else
      test_no_checksum_flags();
`endif
      test_back_pressure();
      test_reset_mid_load();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/key_load_controller.md
# key_load_controller

Sequences the loading of the 64-bit logic-locking key into the locked decode path (main decoder, ALU decoder and the other lock modules) after reset. Accepts key bytes over a valid/ready byte stream, assembles them in a shadow register, optionally verifies an XOR checksum, and only then publishes the full key and releases the core. Sits between the off-core key source (boot ROM, JTAG or secure loader) and the 8-bit key slices consumed by each lock module.

## Interface
- KEY_BYTES, 8, number of key bytes; key width is 8*KEY_BYTES.
- MAX_FAILS, 3, checksum failures tolerated before permanent lockout.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a key load from IDLE or ERROR.
- key_in  in  8  key byte, or checksum byte.
- key_valid  in  1  key_in holds a valid byte.
- key_ready  out  1  controller accepts a byte this cycle.
- key_out  out  8*KEY_BYTES  published key; byte i drives key_out[8i+7:8i]; slice 0 feeds the main decoder.
- armed  out  1  key published; core may execute.
- busy  out  1  load in progress.
- error  out  1  last load failed its checksum.
- lockout  out  1  fail limit reached; held until rst.
- fail_cnt  out  $clog2(MAX_FAILS+1)  checksum failures since reset.

## Operation
- States: IDLE, LOAD, CHECK, ARMED, ERROR, LOCKOUT.
- A byte is accepted on a cycle where key_valid && key_ready.
- IDLE: key_ready=0. start -> LOAD, byte index cleared, shadow and running XOR cleared.
- LOAD: key_ready=1, busy=1. Each accepted byte goes to shadow byte[index], is XORed into the running sum, and index increments. The first byte received lands in the least-significant byte.
- When byte KEY_BYTES-1 is accepted: with checksum compiled in -> CHECK; without it -> ARMED.
- CHECK: key_ready=1, busy=1. The accepted byte is compared with the running XOR.
  - Match -> ARMED.
  - Mismatch -> fail_cnt+1. If the new count equals MAX_FAILS -> LOCKOUT, else -> ERROR. Shadow register cleared.
- ARMED: shadow copied to key_out on the entering edge. armed=1, key_ready=0. start and key_valid are ignored. The key is write-once until rst.
- ERROR: error=1, key_out stays 0. start -> LOAD, clearing error.
- LOCKOUT: lockout=1, key_out=0, key_ready=0. All inputs ignored until rst.
- key_out is never driven with a partial key. It is 0 in every state except ARMED.
- start while in LOAD or CHECK is ignored; the load is not restarted.
- fail_cnt saturates at MAX_FAILS.

## Timing
- Reset values: state=IDLE, key_out=0, armed=0, busy=0, error=0, lockout=0, key_ready=0, fail_cnt=0, shadow=0.
- rst asserted mid-load or while ARMED returns every output to its reset value on the next edge.
- start sampled in IDLE at edge N: key_ready=1 from cycle N+1.
- Throughput is one byte per cycle while key_valid is held high.
- Accepting the final byte at edge M: armed=1 and key_out valid from cycle M+1. Checksum mismatch: error or lockout asserted from cycle M+1.
- key_ready is a registered state decode and does not depend combinationally on key_valid.

## Configuration
- KEYLD_CHECKSUM_EN defined: the CHECK state, running XOR, ERROR and LOCKOUT paths, and fail_cnt are present.
- KEYLD_CHECKSUM_EN undefined: a load is exactly KEY_BYTES bytes followed directly by ARMED. error, lockout and fail_cnt are tied to 0. ERROR and LOCKOUT are unreachable.

## Structure
- Shared package contents: state encoding constants, KEY_BYTES default, and the per-lock-module key slice offsets used when wiring key_out to the decoders.
- One sub-module, key_shadow_reg: byte-addressed shadow register with clear and publish-to-key_out. The FSM and counters stay in key_load_controller.

## Test plan
- Reset then idle: no start -> key_out=0, armed=0, key_ready=0 for 20 cycles.
- Good load (checksum on): bytes 0x57,0x11,0x22,0x33,0x44,0x55,0x66,0x77 then checksum 0x57^...^0x77 -> armed=1 one cycle later, key_out=0x7766554433221157, key_out[7:0]=0x57.
- Bad checksum: same bytes with checksum 0x00 -> error=1, fail_cnt=1, key_out=0. Then start plus a good load -> armed=1, error=0.
- Lockout: three consecutive bad checksums -> lockout=1 and fail_cnt=3. A fourth start is ignored with key_ready=0. After rst, all outputs return to reset values.
- Back-pressure and gaps: key_valid toggling every other cycle -> only accepted bytes counted, and the final key matches.
- Reset mid-load after 4 bytes -> IDLE, key_out=0. A subsequent full load succeeds.
